acc_cpu_mc: RTL and testbench

- Parametrised, multi-cycle successor to the single-cycle accumulator CPU.
- Same accumulator / status-word architecture, with configurable data and address widths and a 4-bit opcode space (16 instructions).
- Adds N and V flags, shifts and a halt instruction.
- Separate instruction and data memory ports with req/ack handshakes, so ROM/RAM of any latency can be attached.
- Sits as the core; the top level wires it to instruction ROM, data RAM and debug outputs.

---
 rtl/acc_cpu_pkg.sv | 60 ++++++
 rtl/acc_alu_w.sv | 104 ++++++++++
 rtl/acc_cpu_mc.sv | 180 ++++++++++++++++++
 tb/tb_acc_cpu_mc.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : acc_cpu_pkg
// Description : Shared constants for the multi-cycle accumulator CPU:
//               opcode map, FSM state codes, status-flag bit positions and
//               instruction-class helpers used by the decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package acc_cpu_pkg;

  localparam int OP_W = 4;

  // Opcode map
  localparam logic [OP_W-1:0] OP_NOP = 4'd0;
  localparam logic [OP_W-1:0] OP_LDA = 4'd1;
  localparam logic [OP_W-1:0] OP_STA = 4'd2;
  localparam logic [OP_W-1:0] OP_ADD = 4'd3;
  localparam logic [OP_W-1:0] OP_SUB = 4'd4;
  localparam logic [OP_W-1:0] OP_AND = 4'd5;
  localparam logic [OP_W-1:0] OP_OR  = 4'd6;
  localparam logic [OP_W-1:0] OP_XOR = 4'd7;
  localparam logic [OP_W-1:0] OP_NOT = 4'd8;
  localparam logic [OP_W-1:0] OP_SHL = 4'd9;
  localparam logic [OP_W-1:0] OP_SHR = 4'd10;
  localparam logic [OP_W-1:0] OP_JMP = 4'd11;
  localparam logic [OP_W-1:0] OP_JZ  = 4'd12;
  localparam logic [OP_W-1:0] OP_JC  = 4'd13;
  localparam logic [OP_W-1:0] OP_JN  = 4'd14;
  localparam logic [OP_W-1:0] OP_HLT = 4'd15;

  // FSM state codes (visible on state_o)
  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_MEM    = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;

  // Status word bit positions: {V,N,C,Z}
  localparam int FLG_Z = 0;
  localparam int FLG_C = 1;
  localparam int FLG_N = 2;
  localparam int FLG_V = 3;

  // Flag-update masks
  localparam logic [3:0] MASK_NONE = 4'b0000;
  localparam logic [3:0] MASK_ZN   = 4'b0101;
  localparam logic [3:0] MASK_ALL  = 4'b1111;

  // LDA..XOR and STA (opcodes 1..7) need a data-memory access.
  function automatic logic needs_mem(input logic [OP_W-1:0] op);
    return (op >= OP_LDA) && (op <= OP_XOR);
  endfunction

  // Accumulator-only operations go straight from DECODE to EXEC.
  function automatic logic is_unary(input logic [OP_W-1:0] op);
    return (op == OP_NOT) || (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/acc_alu_w.sv
`default_nettype none
// ============================================================================
// Module      : acc_alu_w
// Description : Combinational ALU for the accumulator CPU. Produces the
//               result, the candidate flag word and a per-opcode mask telling
//               the core which flag bits this opcode is allowed to update.
// Ports       : acc_i    - current accumulator
//               m_i      - memory operand
//               op_i     - opcode
//               result_o - new accumulator value
//               flags_o  - candidate {V,N,C,Z}
//               mask_o   - 1 = flag bit updated by this opcode
// Revision    : 1.0 - initial release
// ============================================================================
module acc_alu_w
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] acc_i,
  input  logic [DATA_W-1:0] m_i,
  input  logic [OP_W-1:0]   op_i,
  output logic [DATA_W-1:0] result_o,
  output logic [3:0]        flags_o,
  output logic [3:0]        mask_o
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W:0]   add_w;
  logic [DATA_W:0]   sub_w;
  logic [DATA_W-1:0] res_w;
  logic              c_w;
  logic              v_w;

  // Subtraction as acc + ~m + 1: the carry out is the "no borrow" flag.
  assign add_w = {1'b0, acc_i} + {1'b0, m_i};
  assign sub_w = {1'b0, acc_i} + {1'b0, ~m_i} + {{DATA_W{1'b0}}, 1'b1};

  always_comb begin
    res_w  = acc_i;
    c_w    = 1'b0;
    v_w    = 1'b0;
    mask_o = MASK_NONE;
    case (op_i)
      OP_LDA: begin
        res_w  = m_i;
        mask_o = MASK_ZN;
      end
      OP_ADD: begin
        res_w  = add_w[DATA_W-1:0];
        c_w    = add_w[DATA_W];
        v_w    = (acc_i[MSB] == m_i[MSB]) && (add_w[MSB] != acc_i[MSB]);
        mask_o = MASK_ALL;
      end
      OP_SUB: begin
        res_w  = sub_w[DATA_W-1:0];
        c_w    = sub_w[DATA_W];
        v_w    = (acc_i[MSB] != m_i[MSB]) && (sub_w[MSB] != acc_i[MSB]);
        mask_o = MASK_ALL;
      end
      OP_AND: begin
        res_w  = acc_i & m_i;
        mask_o = MASK_ALL;
      end
      OP_OR: begin
        res_w  = acc_i | m_i;
        mask_o = MASK_ALL;
      end
      OP_XOR: begin
        res_w  = acc_i ^ m_i;
        mask_o = MASK_ALL;
      end
      OP_NOT: begin
        res_w  = ~acc_i;
        mask_o = MASK_ALL;
      end
      OP_SHL: begin
        res_w  = {acc_i[MSB-1:0], 1'b0};
        c_w    = acc_i[MSB];
        mask_o = MASK_ALL;
      end
      OP_SHR: begin
        res_w  = {1'b0, acc_i[MSB:1]};
        c_w    = acc_i[0];
        mask_o = MASK_ALL;
      end
      default: begin
        res_w  = acc_i;
        mask_o = MASK_NONE;
      end
    endcase

    flags_o        = 4'b0000;
    flags_o[FLG_Z] = (res_w == '0);
    flags_o[FLG_C] = c_w;
    flags_o[FLG_N] = res_w[MSB];
    flags_o[FLG_V] = v_w;
  end

  assign result_o = res_w;

endmodule
`default_nettype wire

// File: rtl/acc_cpu_mc.sv
`default_nettype none
// ============================================================================
// Module      : acc_cpu_mc
// Description : Multi-cycle accumulator CPU with separate instruction and
//               data memory ports using req/ack handshakes.
//               FSM: FETCH -> DECODE -> (MEM) -> (EXEC) -> FETCH, plus HALT.
// Ports       : clk_i, rst_i (sync, active low)
//               imem_req_o/addr_o/rdata_i/ack_i - instruction fetch port
//               dmem_req_o/we_o/addr_o/wdata_o/rdata_i/ack_i - data port
//               acc_o, flags_o {V,N,C,Z}, pc_o, ir_o, state_o - debug view
//               retire_o - pulse in the cycle an instruction completes
//               halted_o - core parked in HALT
// Revision    : 1.0 - initial release
// ============================================================================
module acc_cpu_mc
  import acc_cpu_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int ADDR_W = 5,
  localparam int INS_W  = OP_W + ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic [INS_W-1:0]  imem_rdata_i,
  input  logic              imem_ack_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  input  logic              dmem_ack_i,
  output logic [DATA_W-1:0] acc_o,
  output logic [3:0]        flags_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [INS_W-1:0]  ir_o,
  output logic [2:0]        state_o,
  output logic              retire_o,
  output logic              halted_o
);

  logic [2:0]        state_q, state_d;
  logic [DATA_W-1:0] acc_q,   acc_d;
  logic [3:0]        flags_q, flags_d;
  logic [ADDR_W-1:0] pc_q,    pc_d;
  logic [INS_W-1:0]  ir_q,    ir_d;
  logic [DATA_W-1:0] opnd_q,  opnd_d;

  logic [OP_W-1:0]   op_w;
  logic [ADDR_W-1:0] arg_w;
  logic [DATA_W-1:0] alu_res_w;
  logic [3:0]        alu_flags_w;
  logic [3:0]        alu_mask_w;

  assign op_w  = ir_q[INS_W-1:ADDR_W];
  assign arg_w = ir_q[ADDR_W-1:0];

  acc_alu_w #(
    .DATA_W (DATA_W)
  ) u_alu (
    .acc_i    (acc_q),
    .m_i      (opnd_q),
    .op_i     (op_w),
    .result_o (alu_res_w),
    .flags_o  (alu_flags_w),
    .mask_o   (alu_mask_w)
  );

  // State and architectural registers
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ST_FETCH;
      acc_q   <= '0;
      flags_q <= '0;
      pc_q    <= '0;
      ir_q    <= '0;
      opnd_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      flags_q <= flags_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      opnd_q  <= opnd_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: begin
        if (imem_ack_i) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (op_w == OP_HLT)       state_d = ST_HALT;
        else if (is_unary(op_w))  state_d = ST_EXEC;
        else if (needs_mem(op_w)) state_d = ST_MEM;
        else                      state_d = ST_FETCH;
      end
      ST_MEM: begin
        if (dmem_ack_i) state_d = (op_w == OP_STA) ? ST_FETCH : ST_EXEC;
      end
      ST_EXEC: state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  // FSM outputs; requests are forced low while reset is asserted so an
  // in-flight transaction is dropped immediately.
  always_comb begin
    imem_req_o = 1'b0;
    dmem_req_o = 1'b0;
    dmem_we_o  = 1'b0;
    retire_o   = 1'b0;
    halted_o   = 1'b0;
    if (rst_i) begin
      case (state_q)
        ST_FETCH: imem_req_o = 1'b1;
        ST_DECODE: retire_o = !needs_mem(op_w) && !is_unary(op_w);
        ST_MEM: begin
          dmem_req_o = 1'b1;
          dmem_we_o  = (op_w == OP_STA);
          retire_o   = dmem_ack_i && (op_w == OP_STA);
        end
        ST_EXEC: retire_o = 1'b1;
        ST_HALT: halted_o = 1'b1;
        default: retire_o = 1'b0;
      endcase
    end
  end

  // Datapath next values
  always_comb begin
    acc_d   = acc_q;
    flags_d = flags_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    opnd_d  = opnd_q;
    case (state_q)
      ST_FETCH: begin
        if (imem_ack_i) begin
          ir_d = imem_rdata_i;
          pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
      end
      ST_DECODE: begin
        // Conditions use the flags left by the previously retired instruction.
        case (op_w)
          OP_JMP: pc_d = arg_w;
          OP_JZ:  if (flags_q[FLG_Z]) pc_d = arg_w;
          OP_JC:  if (flags_q[FLG_C]) pc_d = arg_w;
          OP_JN:  if (flags_q[FLG_N]) pc_d = arg_w;
          default: pc_d = pc_q;
        endcase
      end
      ST_MEM: begin
        if (dmem_ack_i && (op_w != OP_STA)) opnd_d = dmem_rdata_i;
      end
      ST_EXEC: begin
        acc_d   = alu_res_w;
        flags_d = (flags_q & ~alu_mask_w) | (alu_flags_w & alu_mask_w);
      end
      default: acc_d = acc_q;
    endcase
  end

  assign imem_addr_o  = pc_q;
  assign dmem_addr_o  = arg_w;
  assign dmem_wdata_o = acc_q;
  assign acc_o        = acc_q;
  assign flags_o      = flags_q;
  assign pc_o         = pc_q;
  assign ir_o         = ir_q;
  assign state_o      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_acc_cpu_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_acc_cpu_mc
// Description : Self-checking bench for acc_cpu_mc. An 8/5 instance runs a
//               table of two-instruction programs plus hand-written sequences
//               (zero-wait and random-latency memories, branches, PC wrap,
//               reset during a data access); a 16/8 instance checks the wide
//               build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_acc_cpu_mc;
  import acc_cpu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- instance A: DATA_W=8, ADDR_W=5 ----------------
  logic       rst_a = 1'b0;
  logic       imem_req_a, imem_ack_a, dmem_req_a, dmem_we_a, dmem_ack_a;
  logic [4:0] imem_addr_a, dmem_addr_a, pc_a;
  logic [8:0] imem_rdata_a, ir_a;
  logic [7:0] dmem_wdata_a, dmem_rdata_a, acc_a;
  logic [3:0] flags_a;
  logic [2:0] state_a;
  logic       retire_a, halted_a;

  acc_cpu_mc #(.DATA_W(8), .ADDR_W(5)) u_dut_a (
    .clk_i(clk), .rst_i(rst_a),
    .imem_req_o(imem_req_a), .imem_addr_o(imem_addr_a),
    .imem_rdata_i(imem_rdata_a), .imem_ack_i(imem_ack_a),
    .dmem_req_o(dmem_req_a), .dmem_we_o(dmem_we_a), .dmem_addr_o(dmem_addr_a),
    .dmem_wdata_o(dmem_wdata_a), .dmem_rdata_i(dmem_rdata_a), .dmem_ack_i(dmem_ack_a),
    .acc_o(acc_a), .flags_o(flags_a), .pc_o(pc_a), .ir_o(ir_a),
    .state_o(state_a), .retire_o(retire_a), .halted_o(halted_a)
  );

  logic [8:0] rom_a [32];
  logic [7:0] ram_init [32];
  logic [7:0] ram_a [32];
  logic [3:0] i_cnt = 4'd0, i_tgt = 4'd0, d_cnt = 4'd0, d_tgt = 4'd0;
  logic       rand_mode = 1'b0;
  logic       d_stall = 1'b0;

  assign imem_rdata_a = rom_a[imem_addr_a];
  assign dmem_rdata_a = ram_a[dmem_addr_a];
  assign imem_ack_a   = imem_req_a && (i_cnt == i_tgt);
  assign dmem_ack_a   = dmem_req_a && (d_cnt == d_tgt) && !(d_stall && dmem_addr_a == 5'h11);

  always @(posedge clk) begin
    if (imem_req_a && !imem_ack_a) i_cnt <= i_cnt + 4'd1;
    else begin
      i_cnt <= 4'd0;
      i_tgt <= rand_mode ? 4'($urandom_range(0, 3)) : 4'd0;
    end
    if (dmem_req_a && !dmem_ack_a) d_cnt <= d_cnt + 4'd1;
    else begin
      d_cnt <= 4'd0;
      d_tgt <= rand_mode ? 4'($urandom_range(0, 3)) : 4'd0;
    end
    if (!rst_a) ram_a <= ram_init;
    else if (dmem_req_a && dmem_ack_a && dmem_we_a) ram_a[dmem_addr_a] <= dmem_wdata_a;
  end

  // Request-stability and retire monitor (mid-cycle sampling)
  int          stab_err = 0;
  int          retire_tot = 0;
  logic        i_pend = 1'b0, d_pend = 1'b0;
  logic [4:0]  i_addr_s;
  logic [13:0] d_snap;
  always @(negedge clk) begin
    if (rst_a) begin
      if (i_pend && (!imem_req_a || imem_addr_a != i_addr_s)) stab_err++;
      if (d_pend && (!dmem_req_a || {dmem_we_a, dmem_addr_a, dmem_wdata_a} != d_snap)) stab_err++;
      if (retire_a) retire_tot++;
    end
    i_pend   = rst_a && imem_req_a && !imem_ack_a;
    d_pend   = rst_a && dmem_req_a && !dmem_ack_a;
    i_addr_s = imem_addr_a;
    d_snap   = {dmem_we_a, dmem_addr_a, dmem_wdata_a};
  end

  // ---------------- instance B: DATA_W=16, ADDR_W=8 ----------------
  logic        rst_b = 1'b0;
  logic        imem_req_b, dmem_req_b, dmem_we_b, retire_b, halted_b;
  logic [7:0]  imem_addr_b, dmem_addr_b, pc_b;
  logic [11:0] imem_rdata_b, ir_b;
  logic [15:0] dmem_wdata_b, dmem_rdata_b, acc_b;
  logic [3:0]  flags_b;
  logic [2:0]  state_b;
  logic [11:0] rom_b [256];
  logic [15:0] ram_b [256];

  assign imem_rdata_b = rom_b[imem_addr_b];
  assign dmem_rdata_b = ram_b[dmem_addr_b];

  acc_cpu_mc #(.DATA_W(16), .ADDR_W(8)) u_dut_b (
    .clk_i(clk), .rst_i(rst_b),
    .imem_req_o(imem_req_b), .imem_addr_o(imem_addr_b),
    .imem_rdata_i(imem_rdata_b), .imem_ack_i(imem_req_b),
    .dmem_req_o(dmem_req_b), .dmem_we_o(dmem_we_b), .dmem_addr_o(dmem_addr_b),
    .dmem_wdata_o(dmem_wdata_b), .dmem_rdata_i(dmem_rdata_b), .dmem_ack_i(dmem_req_b),
    .acc_o(acc_b), .flags_o(flags_b), .pc_o(pc_b), .ir_o(ir_b),
    .state_o(state_b), .retire_o(retire_b), .halted_o(halted_b)
  );

  // ---------------- helpers ----------------
  function automatic logic [8:0] ins(input logic [3:0] op, input logic [4:0] a);
    return {op, a};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic clear_a();
    for (int i = 0; i < 32; i++) begin
      rom_a[i]    = ins(OP_HLT, 5'd0);
      ram_init[i] = 8'h00;
    end
  endtask

  // Reset instance A, release it and run until HALT (bounded).
  task automatic run_a(input string nm, output int cyc, output int ret);
    int base;
    @(negedge clk) rst_a = 1'b0;
    repeat (2) @(negedge clk);
    base  = retire_tot;
    rst_a = 1'b1;
    cyc   = 0;
    while (!halted_a && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    ret = retire_tot - base;
    chk({nm, " halt reached"}, {31'd0, halted_a}, 32'd1);
  endtask

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] m;
    logic [7:0] e_acc;
    logic [3:0] e_flg;   // {V,N,C,Z}
    int         e_cyc;
  } vec_t;

  vec_t vt[14];
  int   cyc, ret, k;
  logic seen_ff;

  initial begin
    vt[0]  = '{OP_ADD, 8'h7F, 8'h01, 8'h80, 4'b1100, 10};
    vt[1]  = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 4'b0011, 10};
    vt[2]  = '{OP_SUB, 8'h05, 8'h05, 8'h00, 4'b0011, 10};
    vt[3]  = '{OP_SUB, 8'h05, 8'h06, 8'hFF, 4'b0100, 10};
    vt[4]  = '{OP_SUB, 8'h80, 8'h01, 8'h7F, 4'b1010, 10};
    vt[5]  = '{OP_AND, 8'hF0, 8'h3C, 8'h30, 4'b0000, 10};
    vt[6]  = '{OP_OR,  8'h00, 8'h00, 8'h00, 4'b0001, 10};
    vt[7]  = '{OP_XOR, 8'hAA, 8'h55, 8'hFF, 4'b0100, 10};
    vt[8]  = '{OP_NOT, 8'h0F, 8'h00, 8'hF0, 4'b0100, 9};
    vt[9]  = '{OP_SHL, 8'h81, 8'h00, 8'h02, 4'b0010, 9};
    vt[10] = '{OP_SHR, 8'h01, 8'h00, 8'h00, 4'b0011, 9};
    vt[11] = '{OP_NOP, 8'h80, 8'h00, 8'h80, 4'b0100, 8};
    vt[12] = '{OP_ADD, 8'h40, 8'h40, 8'h80, 4'b1100, 10};
    vt[13] = '{OP_SHL, 8'h40, 8'h00, 8'h80, 4'b0100, 9};

    // Reset state
    clear_a();
    repeat (2) @(negedge clk);
    chk("reset ctrl {ireq,dreq,retire,halted,state}",
        {27'd0, imem_req_a, dmem_req_a, retire_a, halted_a, state_a}, 32'd0);
    chk("reset arch {pc,ir,acc,flags}", {6'd0, pc_a, ir_a, acc_a, flags_a}, 32'd0);

    // Table: LDA 0x10 ; <op> 0x11 ; HLT
    for (int v = 0; v < 14; v++) begin
      clear_a();
      rom_a[0] = ins(OP_LDA, 5'h10);
      rom_a[1] = ins(vt[v].op, 5'h11);
      ram_init[5'h10] = vt[v].a;
      ram_init[5'h11] = vt[v].m;
      run_a($sformatf("vec%0d", v), cyc, ret);
      chk($sformatf("vec%0d {acc,flags}", v), {20'd0, acc_a, flags_a}, {20'd0, vt[v].e_acc, vt[v].e_flg});
      chk($sformatf("vec%0d cycles", v), cyc, vt[v].e_cyc);
    end

    // Reference program, zero-wait then random-latency memories
    for (int r = 0; r < 4; r++) begin
      clear_a();
      rand_mode = (r != 0);
      rom_a[0] = ins(OP_LDA, 5'd3);
      rom_a[1] = ins(OP_ADD, 5'd4);
      rom_a[2] = ins(OP_STA, 5'd5);
      ram_init[3] = 8'h7F;
      ram_init[4] = 8'h01;
      run_a($sformatf("prog r%0d", r), cyc, ret);
      if (r == 0) chk("prog cycles to halt", cyc, 13);
      chk($sformatf("prog r%0d RAM[5]", r), {24'd0, ram_a[5]}, 32'h80);
      chk($sformatf("prog r%0d {acc,flags,pc}", r), {15'd0, acc_a, flags_a, pc_a}, {15'd0, 8'h80, 4'b1100, 5'd4});
      chk($sformatf("prog r%0d retires", r), ret, 4);
    end
    chk("request stability", stab_err, 0);
    rand_mode = 1'b0;

    // SUB equal then JZ taken; LDA after it keeps C
    clear_a();
    rom_a[0] = ins(OP_LDA, 5'h10);
    rom_a[1] = ins(OP_SUB, 5'h11);
    rom_a[2] = ins(OP_JZ,  5'h10);
    rom_a[3] = ins(OP_NOP, 5'h00);
    rom_a[5'h10] = ins(OP_LDA, 5'h12);
    ram_init[5'h10] = 8'h05;
    ram_init[5'h11] = 8'h05;
    ram_init[5'h12] = 8'h80;
    run_a("jz taken", cyc, ret);
    chk("jz taken {acc,flags,pc}", {15'd0, acc_a, flags_a, pc_a}, {15'd0, 8'h80, 4'b0110, 5'h12});

    // SUB less then JZ not taken
    ram_init[5'h11] = 8'h06;
    rom_a[3] = ins(OP_HLT, 5'h00);
    run_a("jz not taken", cyc, ret);
    chk("jz not taken {acc,flags,pc}", {15'd0, acc_a, flags_a, pc_a}, {15'd0, 8'hFF, 4'b0100, 5'd4});

    // JN taken after a negative load
    clear_a();
    rom_a[0] = ins(OP_LDA, 5'h10);
    rom_a[1] = ins(OP_JN,  5'h08);
    rom_a[2] = ins(OP_NOP, 5'h00);
    ram_init[5'h10] = 8'h90;
    run_a("jn", cyc, ret);
    chk("jn taken pc", {27'd0, pc_a}, 32'd9);

    // PC wrap: JC(not) LDA SHL JMP 1F, NOP@1F wraps to 0, JC(taken) 4, HLT
    clear_a();
    rom_a[0] = ins(OP_JC,  5'd4);
    rom_a[1] = ins(OP_LDA, 5'h10);
    rom_a[2] = ins(OP_SHL, 5'd0);
    rom_a[3] = ins(OP_JMP, 5'h1F);
    rom_a[5'h1F] = ins(OP_NOP, 5'd0);
    ram_init[5'h10] = 8'h81;
    run_a("wrap", cyc, ret);
    chk("wrap {acc,flags,pc}", {15'd0, acc_a, flags_a, pc_a}, {15'd0, 8'h02, 4'b0010, 5'd5});
    chk("wrap retires", ret, 7);
    chk("wrap cycles", cyc, 17);

    // Reset while a data read is stalled
    clear_a();
    rom_a[0] = ins(OP_LDA, 5'h10);
    rom_a[1] = ins(OP_LDA, 5'h11);
    ram_init[5'h10] = 8'h55;
    ram_init[5'h11] = 8'hAA;
    d_stall = 1'b1;
    @(negedge clk) rst_a = 1'b0;
    repeat (2) @(negedge clk);
    rst_a = 1'b1;
    k = 0;
    while (!(dmem_req_a && dmem_addr_a == 5'h11) && k < 50) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    chk("stalled {dreq,acc,pc}", {18'd0, dmem_req_a, acc_a, pc_a}, {18'd0, 1'b1, 8'h55, 5'd2});
    rst_a = 1'b0;
    #1;
    chk("reset reqs drop", {30'd0, imem_req_a, dmem_req_a}, 32'd0);
    @(negedge clk);
    chk("reset mid {acc,pc,flags,state}", {12'd0, acc_a, pc_a, flags_a, state_a}, 32'd0);
    d_stall = 1'b0;
    rst_a = 1'b1;
    #1;
    chk("after release {state,ireq}", {28'd0, state_a, imem_req_a}, {28'd0, ST_FETCH, 1'b1});

    // Wide build: ADD FFFF + 0001, JMP 0xFF
    for (int i = 0; i < 256; i++) begin
      rom_b[i] = {OP_HLT, 8'h00};
      ram_b[i] = 16'h0000;
    end
    rom_b[0] = {OP_LDA, 8'h10};
    rom_b[1] = {OP_ADD, 8'h11};
    rom_b[2] = {OP_JMP, 8'hFF};
    ram_b[8'h10] = 16'hFFFF;
    ram_b[8'h11] = 16'h0001;
    @(negedge clk) rst_b = 1'b0;
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    seen_ff = 1'b0;
    k = 0;
    while (!halted_b && k < 100) begin
      @(negedge clk);
      if (pc_b == 8'hFF) seen_ff = 1'b1;
      k++;
    end
    chk("wide halt reached", {31'd0, halted_b}, 32'd1);
    chk("wide {acc,flags}", {12'd0, acc_b, flags_b}, {12'd0, 16'h0000, 4'b0011});
    chk("wide pc reached 0xFF", {31'd0, seen_ff}, 32'd1);
    chk("wide pc after HLT@FF", {24'd0, pc_b}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
